fu_issue_scheduler: RTL
=======================

Name: fu_issue_scheduler

Overview:
- Issue-stage scheduler for the pipelined RISC-V core once multi-cycle functional units (ALU, MEM, MUL, DIV) are added.
- Tracks in-flight destination registers (scoreboard), enforces the non-pipelined divider as a structural hazard, and reserves the single register-file write port per cycle.
- Drives the ID-stage stall, and emits the writeback select (unit and rd) each cycle.
- Sits beside HazardDetectionUnit. That unit still owns branch flush; this block gates issue from ID into the function units.

Parameters:
ALU_LAT, 1, cycles from issue grant to writeback for ALU ops
MEM_LAT, 2, cycles from grant to writeback for loads/stores
MUL_LAT, 4, cycles from grant to writeback for the pipelined multiplier
DIV_LAT, 8, cycles from grant to writeback for the non-pipelined divider
WB_DEPTH, 16, writeback reservation slots; each *_LAT must be in 1..WB_DEPTH-1

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
issue_valid_ID  in  1  ID holds a valid instruction requesting issue
fu_type_ID  in  2  00 ALU, 01 MEM, 10 MUL, 11 DIV
rd_ID  in  5  destination register
rs1_ID  in  5  source register 1
rs2_ID  in  5  source register 2
rs1use_ID  in  1  rs1 is read
rs2use_ID  in  1  rs2 is read
RegWrite_ID  in  1  instruction writes rd
flush_ID  in  1  ID instruction squashed this cycle (branch)
issue_grant  out  1  instruction issues this cycle
stall_ID  out  1  hold PC and the IF/ID register this cycle
div_busy  out  1  divider occupied
wb_valid  out  1  register-file write this cycle
wb_fu  out  2  unit whose result is written (fu_type encoding)
wb_rd  out  5  register written
pending_mask  out  32  scoreboard; bit n = write to xn in flight

Behaviour:
- Definitions:
  - writer = RegWrite_ID & rd_ID!=0
  - L = latency parameter selected by fu_type_ID
- Hazards (combinational, from registered state only):
  - RAW: (rs1use_ID & rs1_ID!=0 & pending[rs1_ID]) | (rs2use_ID & rs2_ID!=0 & pending[rs2_ID]).
  - WAW: writer & pending[rd_ID].
  - STRUCT: fu_type_ID==11 & div_busy.
  - WBCONF: writer & the reservation slot that reaches writeback L cycles after this one is occupied.
- Grant and stall:
  - issue_grant = issue_valid_ID & ~flush_ID & ~(RAW|WAW|STRUCT|WBCONF).
  - stall_ID = issue_valid_ID & ~flush_ID & ~issue_grant.
  - Both are combinational.
- No bypass from writeback: a pending bit stays set through its own writeback cycle and clears at the closing edge. A dependent instruction issues no earlier than the cycle after writeback.
- Reservation shift register, WB_DEPTH-1 entries of {valid, fu, rd}:
  - Shifts one slot toward writeback every cycle.
  - On a grant with writer, the entry is inserted so it reaches writeback exactly L cycles after the grant cycle.
  - Writeback is cycle t+L for a grant in cycle t.
- Writeback outputs:
  - wb_valid, wb_fu and wb_rd are registered, driven from the head slot, and asserted for exactly one cycle.
  - wb_fu/wb_rd are 0 when wb_valid=0.
- Grants without writer (stores, rd=x0) issue, reserve no slot, set no pending bit, and produce no wb_valid.
- Scoreboard update at each edge:
  - Set pending[rd_ID] on a grant with writer.
  - Clear pending[wb_rd] if wb_valid.
  - Set and clear of the same bit in one cycle cannot occur, because WAW blocks it.
  - pending[0] is always 0.
- Divider: 4-bit-or-wider down-counter.
  - Loads DIV_LAT on a DIV grant; otherwise decrements when nonzero.
  - div_busy = counter!=0.
  - After a DIV grant in cycle t, div_busy is high during t+1..t+DIV_LAT and the next DIV can be granted in t+DIV_LAT+1.
- flush_ID overrides everything: no grant, no stall, no state change.
- Reset (any cycle, including mid-operation):
  - Clears all reservations, pending_mask, and the divider counter.
  - All outputs are 0 in the cycle after reset.
  - In-flight results are dropped; the datapath flushes its units on the same reset.
- Simultaneous events: a writeback and a new grant to a different rd in the same cycle both take effect at the same edge.

Test Plan:
- rst, then ALU writer rd=5 granted in cycle 0 -> pending[5]=1 in cycle 1; wb_valid=1, wb_fu=00, wb_rd=5 in cycle 1; pending[5]=0 in cycle 2.
- MUL rd=6 granted at t, then ALU with rs1=6 presented from t+1 -> stall_ID=1 for t+1..t+4, issue_grant in t+5.
- MUL rd=7 at t (writeback t+4), MEM load rd=8 presented at t+2 -> WBCONF stall at t+2, grant t+3, writebacks rd=7 at t+4 and rd=8 at t+5.
- DIV rd=9 at t, DIV rd=10 presented from t+1 -> div_busy high t+1..t+8, stall t+1..t+8, grant t+9, writebacks at t+8 and t+17.
- WAW and store: MUL rd=3 at t, ALU rd=3 presented at t+1 -> stall until grant at t+5. A store (RegWrite=0) presented at t+1 instead -> grant at t+1, no wb_valid from it.
- flush_ID=1 while a RAW hazard exists -> stall_ID=0, issue_grant=0, no state change. rst asserted two cycles into a DIV -> div_busy=0, pending_mask=0, and no wb_valid afterwards.

Source files
------------

// File: rtl/fu_issue_scheduler_if.sv
// Issue-side bundle between the ID stage and the issue scheduler.
// The ID stage (master) presents one instruction per cycle. The scheduler
// (slave) returns grant/stall, divider status, the writeback select and the
// scoreboard.
interface fu_issue_scheduler_if;
  // ID -> scheduler
  logic        issue_valid_ID;
  logic [1:0]  fu_type_ID;
  logic [4:0]  rd_ID;
  logic [4:0]  rs1_ID;
  logic [4:0]  rs2_ID;
  logic        rs1use_ID;
  logic        rs2use_ID;
  logic        RegWrite_ID;
  logic        flush_ID;
  // scheduler -> ID / writeback mux
  logic        issue_grant;
  logic        stall_ID;
  logic        div_busy;
  logic        wb_valid;
  logic [1:0]  wb_fu;
  logic [4:0]  wb_rd;
  logic [31:0] pending_mask;

  modport master (
    output issue_valid_ID, fu_type_ID, rd_ID, rs1_ID, rs2_ID,
           rs1use_ID, rs2use_ID, RegWrite_ID, flush_ID,
    input  issue_grant, stall_ID, div_busy, wb_valid, wb_fu, wb_rd,
           pending_mask
  );

  modport slave (
    input  issue_valid_ID, fu_type_ID, rd_ID, rs1_ID, rs2_ID,
           rs1use_ID, rs2use_ID, RegWrite_ID, flush_ID,
    output issue_grant, stall_ID, div_busy, wb_valid, wb_fu, wb_rd,
           pending_mask
  );
endinterface

// File: rtl/fu_issue_scheduler.sv
// Issue-stage scheduler for the multi-cycle functional units.
// It keeps a scoreboard of in-flight destination registers and blocks the
// non-pipelined divider while it is busy. A reservation shift register
// assigns the single register-file write port to exactly one result per
// cycle.
module fu_issue_scheduler #(
  parameter int unsigned ALU_LAT  = 1,
  parameter int unsigned MEM_LAT  = 2,
  parameter int unsigned MUL_LAT  = 4,
  parameter int unsigned DIV_LAT  = 8,
  parameter int unsigned WB_DEPTH = 16
) (
  input logic                clk,
  input logic                rst,
  fu_issue_scheduler_if.slave bus
);

  localparam int unsigned NSLOT = WB_DEPTH - 1;
  localparam int unsigned IDX_W = $clog2(WB_DEPTH);
  localparam int unsigned DCW   = ($clog2(DIV_LAT + 1) < 4) ? 4 : $clog2(DIV_LAT + 1);

  typedef struct packed {
    logic       vld;
    logic [1:0] fu;
    logic [4:0] rd;
  } slot_t;

  // res_q[k] holds the result that is written back k+1 cycles from now.
  slot_t [NSLOT-1:0] res_q, res_d, res_ins;
  slot_t             wb_q, wb_d;
  logic [31:0]       pend_q, pend_d;
  logic [DCW-1:0]    div_cnt_q, div_cnt_d;

  logic [IDX_W-1:0]  lat_idx;
  logic              writer, raw, waw, strct, wbconf, grant, div_busy;

  // The slot that reaches writeback L cycles after this one.
  always_comb begin
    lat_idx = IDX_W'(ALU_LAT - 1);
    case (bus.fu_type_ID)
      2'b00:   lat_idx = IDX_W'(ALU_LAT - 1);
      2'b01:   lat_idx = IDX_W'(MEM_LAT - 1);
      2'b10:   lat_idx = IDX_W'(MUL_LAT - 1);
      default: lat_idx = IDX_W'(DIV_LAT - 1);
    endcase
  end

  // Hazards look only at registered state, so grant has no path through
  // this cycle's writeback. A dependant issues the cycle after writeback.
  always_comb begin
    writer   = bus.RegWrite_ID & (bus.rd_ID != 5'd0);
    div_busy = (div_cnt_q != '0);
    raw      = (bus.rs1use_ID & (bus.rs1_ID != 5'd0) & pend_q[bus.rs1_ID]) |
               (bus.rs2use_ID & (bus.rs2_ID != 5'd0) & pend_q[bus.rs2_ID]);
    waw      = writer & pend_q[bus.rd_ID];
    strct    = (bus.fu_type_ID == 2'b11) & div_busy;
    wbconf   = writer & res_q[lat_idx].vld;
    grant    = bus.issue_valid_ID & ~bus.flush_ID & ~(raw | waw | strct | wbconf);
  end

  // Insert the granted writer, then advance the reservations by one slot.
  always_comb begin
    res_ins = res_q;
    if (grant && writer) begin
      res_ins[lat_idx] = '{vld: 1'b1, fu: bus.fu_type_ID, rd: bus.rd_ID};
    end
    wb_d = res_ins[0];
    res_d = '0;
    for (int k = 0; k < int'(NSLOT) - 1; k++) begin
      res_d[k] = res_ins[k+1];
    end
  end

  // Scoreboard and divider occupancy. WAW blocking keeps a set and a clear
  // of the same bit from landing on the same edge.
  always_comb begin
    pend_d = pend_q;
    if (wb_q.vld) pend_d[wb_q.rd] = 1'b0;
    if (grant && writer) pend_d[bus.rd_ID] = 1'b1;
    pend_d[0] = 1'b0;

    div_cnt_d = div_cnt_q;
    if (grant && (bus.fu_type_ID == 2'b11)) begin
      div_cnt_d = DCW'(DIV_LAT);
    end else if (div_cnt_q != '0) begin
      div_cnt_d = div_cnt_q - 1'b1;
    end
  end

  // State registers. Reset drops every in-flight result.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_q     <= '0;
      wb_q      <= '0;
      pend_q    <= '0;
      div_cnt_q <= '0;
    end else begin
      res_q     <= res_d;
      wb_q      <= wb_d;
      pend_q    <= pend_d;
      div_cnt_q <= div_cnt_d;
    end
  end

  assign bus.issue_grant  = grant;
  assign bus.stall_ID     = bus.issue_valid_ID & ~bus.flush_ID & ~grant;
  assign bus.div_busy     = div_busy;
  assign bus.wb_valid     = wb_q.vld;
  assign bus.wb_fu        = wb_q.fu;
  assign bus.wb_rd        = wb_q.rd;
  assign bus.pending_mask = pend_q;

endmodule
